// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, bit-period helper and frame constants.
// UART_TX_PARITY_EN adds the PARITY state for 8E1 framing.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } uart_tx_state_e;

  // Rounded clock/baud ratio.
  function automatic int unsigned baud_div(input int unsigned clock_freq,
                                           input int unsigned baud_rate);
    return (clock_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is refused
// even when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Width-1:0]       wdata,
  output logic [Width-1:0]       rdata,
  output logic [$clog2(Depth):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = mem[rptr_q];

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined.
// TX line is a register, so it is glitch-free and forced high by reset.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        io_in_valid,
  output logic                        io_in_ready,
  input  logic [7:0]                  io_in_bits,
  output logic                        io_txd,
  output logic                        io_busy,
  output logic [$clog2(FIFO_DEPTH):0] io_count
);

  localparam int unsigned Div  = baud_div(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned CntW = (Div < 2) ? 1 : $clog2(Div);

  if (Div < 2) begin : gen_div_check
    $error("uart_tx_fifo: bit period must be at least 2 clocks");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_depth_check
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_tx_state_e state_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            txd_q;
`ifdef UART_TX_PARITY_EN
  logic            parity_q;
`endif

  logic [7:0] fifo_rdata;
  logic       fifo_full, fifo_empty, pop, baud_end;

  sync_fifo #(
    .Width(8),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (io_in_valid),
    .pop    (pop),
    .wdata  (io_in_bits),
    .rdata  (fifo_rdata),
    .count  (io_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign baud_end    = (baud_q == CntW'(Div - 1));
  // Pop from IDLE, or at the end of STOP so back-to-back frames have no gap.
  assign pop         = !fifo_empty && ((state_q == StIdle) || (state_q == StStop && baud_end));
  assign io_in_ready = !fifo_full;
  assign io_busy     = (state_q != StIdle) || !fifo_empty;
  assign io_txd      = txd_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      baud_q <= baud_end ? '0 : baud_q + CntW'(1);
      if (pop) begin
        shift_q <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
        parity_q <= ^fifo_rdata;
`endif
      end
      unique case (state_q)
        StIdle: begin
          baud_q <= '0;
          if (pop) begin
            txd_q   <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_end) begin
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= StData;
          end
        end
        StData: begin
          if (baud_end) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              txd_q   <= parity_q;
              state_q <= StParity;
`else
              txd_q   <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (baud_end) begin
            txd_q   <= 1'b1;
            state_q <= StStop;
          end
        end
`endif
        StStop: begin
          if (baud_end) begin
            if (pop) begin
              txd_q   <= 1'b0;
              state_q <= StStart;
            end else begin
              txd_q   <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV = 10 with a 4-entry FIFO; a line monitor
// decodes frames. Parity checks are added when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo;

  localparam int unsigned ClockFreq = 1_000_000;
  localparam int unsigned BaudRate  = 100_000;
  localparam int unsigned Depth     = 4;
  localparam int          Div       = 10;
`ifdef UART_TX_PARITY_EN
  localparam int          FrameBits = 11;
`else
  localparam int          FrameBits = 10;
`endif
  localparam int          FrameLen  = FrameBits * Div;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       io_in_valid = 1'b0;
  logic [7:0] io_in_bits = 8'h00;
  logic       io_in_ready, io_txd, io_busy;
  logic [2:0] io_count;

  int cyc = 0;
  int rst_events = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    logic       start_bit;
    logic       par_bit;
    logic       stop_bit;
    int         start_cyc;
  } frame_t;
  frame_t frames[$];

  uart_tx_fifo #(
    .CLOCK_FREQ(ClockFreq),
    .BAUD_RATE (BaudRate),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready),
    .io_in_bits (io_in_bits),
    .io_txd     (io_txd),
    .io_busy    (io_busy),
    .io_count   (io_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge reset_n) rst_events <= rst_events + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Leaves io_in_valid high so consecutive calls push on consecutive edges.
  task automatic push_byte(input logic [7:0] b, output int edge_cyc);
    io_in_bits  = b;
    io_in_valid = 1'b1;
    for (int n = 0; n < 500 && !io_in_ready; n++) step(1);
    check_eq("push_ready", 32'(io_in_ready), 1);
    step(1);
    edge_cyc = cyc;
  endtask

  task automatic wait_idle(output int c);
    for (int n = 0; n < 3000 && io_busy; n++) step(1);
    check_eq("idle_timeout", 32'(io_busy), 0);
    c = cyc;
  endtask

  task automatic check_frame(input int idx, input logic [7:0] exp);
    if (idx < frames.size()) begin
      check_eq("frame_data", 32'(frames[idx].data), 32'(exp));
      check_eq("frame_start_bit", 32'(frames[idx].start_bit), 0);
      check_eq("frame_stop_bit", 32'(frames[idx].stop_bit), 1);
`ifdef UART_TX_PARITY_EN
      check_eq("frame_parity", 32'(frames[idx].par_bit), 32'(^exp));
`endif
    end else begin
      check_eq("frame_missing", frames.size(), idx + 1);
    end
  endtask

  // Samples each bit in its middle; frames cut by a reset are dropped.
  initial begin : monitor
    frame_t f;
    logic [FrameBits-1:0] bits;
    int rst_mark;
    forever begin
      @(posedge clock);
      #1;
      if (reset_n && !io_txd) begin
        f.start_cyc = cyc;
        rst_mark    = rst_events;
        for (int b = 0; b < FrameBits; b++) begin
          repeat ((b == 0) ? Div / 2 : Div) @(posedge clock);
          #1;
          bits[b] = io_txd;
        end
        if (rst_mark == rst_events && reset_n) begin
          f.start_bit = bits[0];
          f.data      = bits[8:1];
          f.par_bit   = bits[FrameBits-2];
          f.stop_bit  = bits[FrameBits-1];
          frames.push_back(f);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin : main
    int p, q, c, base;
    logic [7:0] exp_b2b [3];
    exp_b2b[0] = 8'h00;
    exp_b2b[1] = 8'hFF;
    exp_b2b[2] = 8'h55;

    step(3);
    check_eq("rst_txd", 32'(io_txd), 1);
    check_eq("rst_ready", 32'(io_in_ready), 1);
    check_eq("rst_busy", 32'(io_busy), 0);
    check_eq("rst_count", 32'(io_count), 0);
    reset_n = 1'b1;
    step(2);

    // Single byte 0xA5.
    push_byte(8'hA5, p);
    io_in_valid = 1'b0;
    check_eq("single_count", 32'(io_count), 1);
    check_eq("single_txd_pre", 32'(io_txd), 1);
    step(1);
    check_eq("single_txd_fall", 32'(io_txd), 0);
    wait_idle(c);
    check_eq("single_busy_len", c - p, 1 + FrameLen);
    check_eq("single_frames", frames.size(), 1);
    check_frame(0, 8'hA5);
    if (frames.size() > 0) check_eq("single_start_cyc", frames[0].start_cyc, p + 1);
    step(10);
    check_eq("single_line_idle", 32'(io_txd), 1);

    // Back-to-back 0x00, 0xFF, 0x55.
    base = frames.size();
    push_byte(8'h00, p);
    push_byte(8'hFF, q);
    push_byte(8'h55, q);
    io_in_valid = 1'b0;
    check_eq("b2b_count_peak", 32'(io_count), 2);
    wait_idle(c);
    check_eq("b2b_total", c - (p + 1), 3 * FrameLen);
    check_eq("b2b_frames", frames.size() - base, 3);
    for (int i = 0; i < 3; i++) check_frame(base + i, exp_b2b[i]);
    if (frames.size() == base + 3) begin
      check_eq("b2b_gap1", frames[base+1].start_cyc - frames[base].start_cyc, FrameLen);
      check_eq("b2b_gap2", frames[base+2].start_cyc - frames[base+1].start_cyc, FrameLen);
    end

    // Full FIFO with valid held high and incrementing bytes.
    base = frames.size();
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i), p);
    check_eq("full_count", 32'(io_count), 4);
    check_eq("full_ready", 32'(io_in_ready), 0);
    io_in_bits = 8'h15;
    step(3);
    check_eq("full_refused", 32'(io_count), 4);
    for (int i = 5; i < 8; i++) push_byte(8'h10 + 8'(i), p);
    io_in_valid = 1'b0;
    wait_idle(c);
    check_eq("full_frames", frames.size() - base, 8);
    for (int i = 0; i < 8; i++) check_frame(base + i, 8'h10 + 8'(i));

    // Push on the edge that ends STOP while one byte is queued.
    base = frames.size();
    push_byte(8'hC3, p);
    push_byte(8'h81, q);
    io_in_valid = 1'b0;
    check_eq("simul_count_pre", 32'(io_count), 1);
    step(FrameLen - 1);
    push_byte(8'h7E, c);
    io_in_valid = 1'b0;
    check_eq("simul_edge", c - q, FrameLen);
    check_eq("simul_count", 32'(io_count), 1);
    check_eq("simul_txd_start", 32'(io_txd), 0);
    wait_idle(c);
    check_eq("simul_frames", frames.size() - base, 3);
    check_frame(base, 8'hC3);
    check_frame(base + 1, 8'h81);
    check_frame(base + 2, 8'h7E);

    // Reset during DATA bit 3 (bit 3 of 0xA4 is 0).
    base = frames.size();
    push_byte(8'hA4, p);
    push_byte(8'h66, q);
    io_in_valid = 1'b0;
    step(45);
    check_eq("rstmid_txd_pre", 32'(io_txd), 0);
    reset_n = 1'b0;
    #1;
    check_eq("rstmid_txd", 32'(io_txd), 1);
    check_eq("rstmid_count", 32'(io_count), 0);
    check_eq("rstmid_busy", 32'(io_busy), 0);
    #2;
    reset_n = 1'b1;
    step(60);
    check_eq("rstmid_no_resume", 32'(io_busy), 0);
    check_eq("rstmid_no_frame", frames.size(), base);
    push_byte(8'h3C, p);
    io_in_valid = 1'b0;
    wait_idle(c);
    check_eq("rstmid_len", c - p, 1 + FrameLen);
    check_eq("rstmid_frames", frames.size() - base, 1);
    check_frame(base, 8'h3C);

`ifdef UART_TX_PARITY_EN
    base = frames.size();
    push_byte(8'h07, p);
    io_in_valid = 1'b0;
    wait_idle(c);
    check_eq("par_len", c - p, 1 + 110);
    check_eq("par_frames", frames.size() - base, 1);
    if (frames.size() > base) check_eq("par_bit", 32'(frames[base].par_bit), 1);
    check_frame(base, 8'h07);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
